// File: rtl/align_pkg.sv
// rtl/align_pkg.sv - shared widths, FSM states and frame helpers for align_arb
package align_pkg;

    localparam int PIX_W  = 16;
    localparam int ADDR_W = 20;

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_WAIT_VS = 1'b1
    } state_t;

    // Pixels in one frame; evaluated at elaboration for the address checks.
    function automatic int frame_pixels(input int h, input int v);
        return h * v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_elig,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the pointer upward, wrapping, and take the first eligible index.
    always_comb begin
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(i_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!o_any && i_elig[IDX_W'(j)]) begin
                o_any               = 1'b1;
                o_grant[IDX_W'(j)]  = 1'b1;
                o_idx               = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/align_arb.sv
// rtl/align_arb.sv - round-robin pixel arbiter and frame sequencer (option: ALIGN_ARB_STATS_EN)
module align_arb
    import align_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int H_DISP     = 1280,
    parameter int V_DISP     = 720,
    parameter int FIFO_DEPTH = H_DISP + 64,
    parameter int HEADROOM   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ*PIX_W-1:0]         req_data,
    input  logic [NREQ*ADDR_W-1:0]        req_addr,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [$clog2(FIFO_DEPTH):0]   fill_level,
    input  logic                          frame_vs,
    output logic [PIX_W-1:0]              out_data,
    output logic [ADDR_W-1:0]             out_addr,
    output logic                          out_valid,
    output logic [NREQ-1:0]               frame_done,
    output logic                          err_addr,
    output logic                          err_sync
`ifdef ALIGN_ARB_STATS_EN
    ,
    output logic [20:0]                   stat_pix,
    output logic [31:0]                   stat_stall
`endif
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] FRAME_PIX    = ADDR_W'(frame_pixels(H_DISP, V_DISP));
    localparam logic [ADDR_W-1:0] LAST_ADDR    = FRAME_PIX - 1'b1;
    localparam logic [FILL_W-1:0] THROTTLE_LVL = FILL_W'(FIFO_DEPTH - HEADROOM);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_idx;
    logic [NREQ-1:0]    r_frame_done;
    logic [NREQ-1:0]    w_elig;
    logic [NREQ-1:0]    w_grant;
    logic [NREQ-1:0]    w_done_set;
    logic [NREQ-1:0]    w_done_nxt;
    logic               w_any;
    logic               w_throttle;
    logic               w_arb_en;
    logic               w_xfer;
    logic               w_in_range;
    logic               w_fwd;
    logic               w_last;
    logic               w_vs_restart;
    logic [PIX_W-1:0]   w_data_arr [NREQ];
    logic [ADDR_W-1:0]  w_addr_arr [NREQ];
    logic [PIX_W-1:0]   w_sel_data;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic               r_out_valid;
    logic [PIX_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]  r_out_addr;
    logic               r_err_addr;
    logic               r_err_sync;

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_unpack
            assign w_data_arr[g] = req_data[g*PIX_W +: PIX_W];
            assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        end
    endgenerate

    assign w_elig = req_valid & ~r_frame_done;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_data   = w_data_arr[w_idx];
    assign w_sel_addr   = w_addr_arr[w_idx];
    assign w_xfer       = w_arb_en && w_any;
    assign w_in_range   = (w_sel_addr < FRAME_PIX);
    assign w_fwd        = w_xfer && w_in_range;
    assign w_last       = w_fwd && (w_sel_addr == LAST_ADDR);
    assign w_done_set   = w_last ? w_grant : '0;
    assign w_done_nxt   = r_frame_done | w_done_set;
    assign w_vs_restart = (r_state == S_WAIT_VS) && frame_vs;

    assign req_ready  = w_arb_en ? w_grant : '0;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_addr   = r_out_addr;
    assign frame_done = r_frame_done;
    assign err_addr   = r_err_addr;
    assign err_sync   = r_err_sync;

    // Next state and grant enable; grants only while running, unthrottled and out of reset.
    always_comb begin
        w_state_nxt = r_state;
        w_throttle  = (fill_level >= THROTTLE_LVL);
        w_arb_en    = (r_state == S_RUN) && !w_throttle && !rst;
        case (r_state)
            S_RUN: begin
                if (&w_done_nxt) begin
                    w_state_nxt = S_WAIT_VS;
                end
            end
            S_WAIT_VS: begin
                if (frame_vs) begin
                    w_state_nxt = S_RUN;
                end
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin pointer and per-requester frame-done mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_frame_done <= '0;
        end else if (w_vs_restart) begin
            r_ptr        <= '0;
            r_frame_done <= '0;
        end else begin
            r_frame_done <= w_done_nxt;
            if (w_xfer) begin
                r_ptr <= (w_idx == IDX_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    // One-cycle output stage; data/addr hold when nothing is forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
        end else begin
            r_out_valid <= w_fwd;
            if (w_fwd) begin
                r_out_data <= w_sel_data;
                r_out_addr <= w_sel_addr;
            end
        end
    end

    // Sticky error flags: out-of-frame address, and vsync arriving mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_addr <= 1'b0;
            r_err_sync <= 1'b0;
        end else begin
            if (w_xfer && !w_in_range) begin
                r_err_addr <= 1'b1;
            end
            if (frame_vs && (r_state == S_RUN)) begin
                r_err_sync <= 1'b1;
            end
        end
    end

`ifdef ALIGN_ARB_STATS_EN
    logic [20:0] r_pix_cnt;
    logic [20:0] r_stat_pix;
    logic [31:0] r_stat_stall;

    assign stat_pix   = r_stat_pix;
    assign stat_stall = r_stat_stall;

    // Per-frame forwarded-beat count, published when the next frame starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt  <= '0;
            r_stat_pix <= '0;
        end else if (w_vs_restart) begin
            r_stat_pix <= r_pix_cnt;
            r_pix_cnt  <= '0;
        end else if (w_fwd) begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
        end
    end

    // Saturating count of cycles where someone wants to send but the FIFO is too full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_stall <= '0;
        end else if ((|w_elig) && w_throttle && (r_stat_stall != '1)) begin
            r_stat_stall <= r_stat_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_align_arb.sv
// tb/tb_align_arb.sv - self-checking bench for align_arb (table, corner sequences, random vs model)
module tb_align_arb;

    localparam int NREQ  = 4;
    localparam int H     = 4;
    localparam int V     = 2;
    localparam int DEPTH = 1344;
    localparam int HR    = 32;
    localparam int LIMIT = DEPTH - HR;
    localparam int NPIX  = H * V;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  req_data;
    logic [79:0]  req_addr;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [11:0]  fill_level;
    logic         frame_vs;
    logic [15:0]  out_data;
    logic [19:0]  out_addr;
    logic         out_valid;
    logic [3:0]   frame_done;
    logic         err_addr;
    logic         err_sync;
`ifdef ALIGN_ARB_STATS_EN
    logic [20:0]  stat_pix;
    logic [31:0]  stat_stall;
`endif

    logic [15:0]  d_arr [NREQ];
    logic [19:0]  a_arr [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        req_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*16 +: 16] = d_arr[i];
            req_addr[i*20 +: 20] = a_arr[i];
        end
    end

    align_arb #(
        .NREQ(NREQ), .H_DISP(H), .V_DISP(V), .FIFO_DEPTH(DEPTH), .HEADROOM(HR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
        .fill_level(fill_level), .frame_vs(frame_vs),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .frame_done(frame_done), .err_addr(err_addr), .err_sync(err_sync)
`ifdef ALIGN_ARB_STATS_EN
        , .stat_pix(stat_pix), .stat_stall(stat_stall)
`endif
    );

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] fill;
        logic [3:0]  exp_ready;
    } vec_t;

    vec_t tbl [14];
    int   ord [4] = '{3, 2, 0, 1};
    int   n_vec = 0;
    int   n_err = 0;

    // reference model state
    int          m_ptr;
    logic [3:0]  m_done;
    logic        m_wait;
    logic        m_erra, m_errs, m_ov;
    logic [15:0] m_od;
    logic [19:0] m_oa;
    int          m_pix, m_stat_pix;
    longint      m_stall;
    logic [3:0]  hold;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic [3:0] exp_rdy);
        #1;
        chk(nm, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic only(input int i, input logic [19:0] a);
        req_valid = 4'(1 << i);
        a_arr[i]  = a;
        d_arr[i]  = 16'(16'h0100 + i);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        frame_vs   = 1'b0;
        fill_level = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        frame_vs   = 1'b0;
        fill_level = '0;
        for (int i = 0; i < NREQ; i++) begin
            d_arr[i] = '0;
            a_arr[i] = '0;
        end
        tbl[0]  = '{4'hF, 12'd0,    4'b0001};
        tbl[1]  = '{4'hF, 12'd0,    4'b0010};
        tbl[2]  = '{4'hF, 12'd0,    4'b0100};
        tbl[3]  = '{4'hF, 12'd0,    4'b1000};
        tbl[4]  = '{4'hF, 12'd0,    4'b0001};
        tbl[5]  = '{4'hF, 12'd0,    4'b0010};
        tbl[6]  = '{4'hA, 12'd0,    4'b1000};
        tbl[7]  = '{4'hA, 12'd0,    4'b0010};
        tbl[8]  = '{4'hA, 12'd0,    4'b1000};
        tbl[9]  = '{4'hF, 12'd1310, 4'b0001};
        tbl[10] = '{4'hF, 12'd1311, 4'b0010};
        tbl[11] = '{4'hF, 12'd1312, 4'b0000};
        tbl[12] = '{4'hF, 12'd1313, 4'b0000};
        tbl[13] = '{4'hF, 12'd1311, 4'b0100};

        // reset state
        @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_odata", 32'(out_data), 0);
        chk("rst_oaddr", 32'(out_addr), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_errs", 32'({err_addr, err_sync}), 0);
        do_reset();

        // table: rotation, sparse requesters, throttle threshold
        for (int r = 0; r < 14; r++) begin
            int idx;
            idx = 0;
            for (int i = 0; i < NREQ; i++) begin
                d_arr[i] = 16'(16'hA000 + r * 16 + i);
                a_arr[i] = 20'(r % 7);
                if (tbl[r].exp_ready[i]) idx = i;
            end
            req_valid  = tbl[r].valid;
            fill_level = tbl[r].fill;
            step($sformatf("tbl%0d_ready", r), tbl[r].exp_ready);
            chk($sformatf("tbl%0d_ovalid", r), 32'(out_valid), 32'(|tbl[r].exp_ready));
            if (tbl[r].exp_ready != 0) begin
                chk($sformatf("tbl%0d_odata", r), 32'(out_data), 32'(16'hA000 + r * 16 + idx));
                chk($sformatf("tbl%0d_oaddr", r), 32'(out_addr), 32'(r % 7));
            end
        end
`ifdef ALIGN_ARB_STATS_EN
        chk("tbl_stall", stat_stall, 2);
`endif

        // full 4x2 frame: one ordinary beat then the last pixel per requester
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            only(i, 20'(i));
            step("frm_a_ready", 4'(1 << i));
            chk("frm_a_oaddr", 32'(out_addr), 32'(i));
            chk("frm_a_done", 32'(frame_done), 0);
        end
        begin
            logic [3:0] mask;
            mask = '0;
            for (int k = 0; k < NREQ; k++) begin
                only(ord[k], 20'(NPIX - 1));
                mask[ord[k]] = 1'b1;
                step("frm_b_ready", 4'(1 << ord[k]));
                chk("frm_b_ovalid", 32'(out_valid), 1);
                chk("frm_b_done", 32'(frame_done), 32'(mask));
            end
        end
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) a_arr[i] = '0;
        step("wait_ready0", 4'b0000);
        chk("wait_ovalid", 32'(out_valid), 0);
        step("wait_ready1", 4'b0000);
        frame_vs = 1'b1;
        step("vs_ready", 4'b0000);
        frame_vs = 1'b0;
        chk("vs_done_clr", 32'(frame_done), 0);
        chk("vs_no_errsync", 32'(err_sync), 0);
`ifdef ALIGN_ARB_STATS_EN
        chk("stat_pix", 32'(stat_pix), NPIX);
`endif
        step("resume_ptr0", 4'b0001);

        // last beat and frame_vs in the same cycle
        for (int i = 0; i < 3; i++) begin
            only(i, 20'(NPIX - 1));
            step("sim_ready", 4'(1 << i));
        end
        only(3, 20'(NPIX - 1));
        frame_vs = 1'b1;
        step("sim_last_ready", 4'b1000);
        frame_vs = 1'b0;
        chk("sim_errsync", 32'(err_sync), 1);
        chk("sim_done", 32'(frame_done), 32'hF);
        req_valid = 4'hF;
        step("sim_waiting", 4'b0000);
        frame_vs = 1'b1;
        step("sim_vs", 4'b0000);
        frame_vs = 1'b0;
        step("sim_resume", 4'b0001);

        // out-of-range beat, vsync in run, reset mid-frame
        do_reset();
        only(0, 20'(NPIX));
        step("oor_ready", 4'b0001);
        chk("oor_ovalid", 32'(out_valid), 0);
        chk("oor_erraddr", 32'(err_addr), 1);
        req_valid = '0;
        step("idle_ready", 4'b0000);
        chk("oor_sticky", 32'(err_addr), 1);
        frame_vs = 1'b1;
        step("vsrun_ready", 4'b0000);
        frame_vs = 1'b0;
        chk("vsrun_errsync", 32'(err_sync), 1);
        only(1, 20'd3);
        step("vsrun_stillrun", 4'b0010);
        chk("pre_rst_ovalid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("arst_ovalid", 32'(out_valid), 0);
        chk("arst_oaddr", 32'(out_addr), 0);
        chk("arst_odata", 32'(out_data), 0);
        chk("arst_errs", 32'({err_addr, err_sync}), 0);
        chk("arst_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized traffic against the behavioural model
        do_reset();
        m_ptr = 0; m_done = '0; m_wait = 1'b0; m_erra = 1'b0; m_errs = 1'b0;
        m_ov = 1'b0; m_od = '0; m_oa = '0; m_pix = 0; m_stat_pix = 0; m_stall = 0;
        hold = '0;
        for (int c = 0; c < 800; c++) begin
            int gnt;
            logic [3:0] exp_r;
            for (int i = 0; i < NREQ; i++) begin
                if (!hold[i]) begin
                    int r;
                    r = int'($urandom_range(0, 31));
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    if (r == 0)      a_arr[i] = 20'(NPIX + int'($urandom_range(0, 7)));
                    else if (r < 3)  a_arr[i] = 20'(NPIX - 1);
                    else             a_arr[i] = 20'($urandom_range(0, NPIX - 2));
                    d_arr[i] = 16'($urandom);
                end
            end
            fill_level = ($urandom_range(0, 3) == 0) ? 12'(LIMIT - 3 + int'($urandom_range(0, 6)))
                                                      : 12'($urandom_range(0, LIMIT - 1));
            frame_vs = ($urandom_range(0, 24) == 0);
            gnt = -1;
            if (!m_wait && int'(fill_level) < LIMIT) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (gnt < 0 && req_valid[(m_ptr + k) % NREQ] && !m_done[(m_ptr + k) % NREQ])
                        gnt = (m_ptr + k) % NREQ;
                end
            end
            exp_r = (gnt >= 0) ? 4'(1 << gnt) : 4'b0000;
            if ((|(req_valid & ~m_done)) && int'(fill_level) >= LIMIT) m_stall++;
            step("rnd_ready", exp_r);
            m_ov = 1'b0;
            if (gnt >= 0) begin
                m_ptr = (gnt + 1) % NREQ;
                if (int'(a_arr[gnt]) < NPIX) begin
                    m_ov = 1'b1;
                    m_od = d_arr[gnt];
                    m_oa = a_arr[gnt];
                    m_pix++;
                    if (int'(a_arr[gnt]) == NPIX - 1) m_done[gnt] = 1'b1;
                end else begin
                    m_erra = 1'b1;
                end
            end
            if (!m_wait) begin
                if (frame_vs) m_errs = 1'b1;
                if (m_done == 4'hF) m_wait = 1'b1;
            end else if (frame_vs) begin
                m_wait = 1'b0;
                m_done = '0;
                m_ptr = 0;
                m_stat_pix = m_pix;
                m_pix = 0;
            end
            chk("rnd_ovalid", 32'(out_valid), 32'(m_ov));
            chk("rnd_odata", 32'(out_data), 32'(m_od));
            chk("rnd_oaddr", 32'(out_addr), 32'(m_oa));
            chk("rnd_done", 32'(frame_done), 32'(m_done));
            chk("rnd_errs", 32'({err_addr, err_sync}), 32'({m_erra, m_errs}));
`ifdef ALIGN_ARB_STATS_EN
            chk("rnd_statpix", 32'(stat_pix), 32'(m_stat_pix));
            chk("rnd_stall", stat_stall, 32'(m_stall));
`endif
            for (int i = 0; i < NREQ; i++) hold[i] = req_valid[i] && (gnt != i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/align_arb.md
Name: align_arb

Overview:
- Round-robin arbiter and frame sequencer in front of the align (sort + line FIFO) datapath.
- Shares the single pixel-write port among NREQ pixel producers (render tiles); each producer issues (data, addr) beats.
- Throttles producers from the downstream FIFO fill level and gates each new frame on the aligned vertical-sync pulse, so lines never overflow and frames never interleave.

Parameters:
NREQ, 4, number of requesters (2..8)
H_DISP, 1280, active pixels per line
V_DISP, 720, active lines per frame
FIFO_DEPTH, H_DISP+64, depth of the downstream line FIFO
HEADROOM, 32, free-entry margin; covers fill_level latency plus sort pipeline depth

Ports:
clk  in  1  clock
rst  in  1  reset
req_data  in  NREQ*16  pixel data, requester i at [16i+15:16i]
req_addr  in  NREQ*20  linear pixel address y*H_DISP+x, requester i at [20i+19:20i]
req_valid  in  NREQ  beat valid per requester
req_ready  out  NREQ  one-hot grant; a transfer occurs when valid&ready
fill_level  in  $clog2(FIFO_DEPTH)+1  downstream FIFO write count
frame_vs  in  1  single-cycle aligned frame-end pulse from the align block
out_data  out  16  granted pixel
out_addr  out  20  granted address
out_valid  out  1  beat strobe into the align block
frame_done  out  NREQ  per-requester "last pixel sent this frame" mask
err_addr  out  1  sticky: a beat had addr >= H_DISP*V_DISP
err_sync  out  1  sticky: frame_vs arrived while in S_RUN

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- Outputs under reset: out_valid=0, out_data=0, out_addr=0, frame_done=0, err_addr=0, err_sync=0, req_ready=0, state=S_RUN, round-robin pointer=0.
- Handshake:
  - Producer holds data/addr stable while valid && !ready.
  - req_ready is combinational from req_valid, frame_done, pointer, throttle and state.
  - At most one bit of req_ready is high per cycle.
- Eligibility: requester i is eligible when req_valid[i] && !frame_done[i].
- Throttle: no grant while fill_level >= FIFO_DEPTH-HEADROOM.
- Arbitration: the grant goes to the first eligible index at or after the pointer, wrapping modulo NREQ. After a transfer, pointer <= granted index + 1 (wraps to 0). With no transfer, the pointer holds.
- Datapath: latency 1. The cycle after a transfer, out_valid=1 with the registered data/addr; otherwise out_valid=0. out_data/out_addr hold their last value when out_valid=0.
- Address range:
  - A beat with addr >= H_DISP*V_DISP is still consumed (ready given) but not forwarded, and err_addr is set.
  - Compare at 20 bits; the constant is computed at elaboration.
- Frame end: a forwarded beat with addr == H_DISP*V_DISP-1 sets frame_done[i] on the same edge.
- States:
  - S_RUN:
    - Arbitrates as above.
    - When frame_done is all-ones (including the edge that sets the final bit), go to S_WAIT_VS.
    - frame_vs seen in S_RUN sets err_sync; the state is unchanged.
  - S_WAIT_VS:
    - req_ready=0.
    - On frame_vs: clear frame_done, set pointer=0, go to S_RUN.
- Simultaneous events:
  - Final-done beat and frame_vs in the same S_RUN cycle: err_sync is set, and the FSM enters S_WAIT_VS (it waits for the next pulse).
- Reset mid-frame: all state clears immediately. Any in-flight out_valid is dropped; the downstream align block is reset by the same rst.

Optional Feature:
- Macro ALIGN_ARB_STATS_EN.
- When defined, the block adds:
  - Output stat_pix[20:0]: count of forwarded beats in the last completed frame. The running counter is latched into stat_pix and then cleared on the S_WAIT_VS->S_RUN transition.
  - Output stat_stall[31:0]: cycles with an eligible requester but throttle active. Free-running, saturates at all-ones, cleared by rst.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Package align_pkg holds:
  - PIX_W=16 and ADDR_W=20.
  - The state enum {S_RUN, S_WAIT_VS}.
  - A function frame_pixels(H,V) returning H*V.
- One sub-module, rr_pick (NREQ-wide round-robin priority picker):
  - Inputs: eligibility vector and pointer.
  - Outputs: one-hot grant and binary index.
  - Purely combinational; instantiated once.

Test Plan:
- NREQ=4, all four valid continuously, fill_level=0 -> grants cycle 0,1,2,3,0…; out_valid high every cycle; data matches with 1-cycle latency.
- Requesters 1 and 3 valid only, pointer=2 -> grant 3, then 1, then 3; no grant to an invalid index.
- fill_level stepped 1310->1311->1312 with defaults (limit 1312) -> req_ready goes to 0 at 1312 and recovers when fill_level drops to 1311.
- H_DISP=4, V_DISP=2: each requester sends addr 7 in turn -> frame_done fills and the FSM enters S_WAIT_VS. Further valids get no ready. frame_vs pulse -> done mask clears and grants resume from index 0.
- Beat with addr 8 (H=4,V=2) -> consumed, out_valid stays 0, err_addr=1 and sticky until rst.
- frame_vs in S_RUN -> err_sync=1; rst asserted mid-frame -> all outputs zero asynchronously. With ALIGN_ARB_STATS_EN, stat_pix=8 after the frame_vs in the 4x2 case.
